// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage pipeline sequencer: stage valids, stall/flush/bubble,
// EX operand forwarding selects and interrupt drain-and-take FSM.
module otter_hazard_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] DE_RS1_ADDR,
  input  logic [4:0] DE_RS2_ADDR,
  input  logic       DE_RS1_USED,
  input  logic       DE_RS2_USED,
  input  logic [4:0] EX_RS1_ADDR,
  input  logic [4:0] EX_RS2_ADDR,
  input  logic       EX_RS1_USED,
  input  logic       EX_RS2_USED,
  input  logic [4:0] EX_RD_ADDR,
  input  logic       EX_MEMREAD,
  input  logic [4:0] MEM_RD_ADDR,
  input  logic [4:0] WB_RD_ADDR,
  input  logic       MEM_REGWRITE,
  input  logic       WB_REGWRITE,
  input  logic       EX_REDIRECT,
  input  logic       INTR,
  input  logic       MIE,
  output logic       PC_WRITE,
  output logic       IF_DE_WRITE,
  output logic       IF_DE_FLUSH,
  output logic       DE_BUBBLE,
  output logic       DE_VALID,
  output logic       EX_VALID,
  output logic       MEM_VALID,
  output logic       WB_VALID,
  output logic [1:0] FWD_A_SEL,
  output logic [1:0] FWD_B_SEL,
  output logic       INT_TAKEN
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_TAKE
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_int_taken;
  logic       r_v_de;
  logic       r_v_ex;
  logic       r_v_mem;
  logic       r_v_wb;

  logic w_redir;
  logic w_int_req;
  logic w_lu_hit;
  logic w_load_use;
  logic w_idle;
  logic w_m_redir;
  logic w_m_entry;
  logic w_m_stall;
  logic w_m_drain;
  logic w_m_take;

  assign w_redir   = r_v_ex & EX_REDIRECT;
  assign w_int_req = INTR & MIE;

  assign w_lu_hit =
    (DE_RS1_USED && (DE_RS1_ADDR == EX_RD_ADDR)) ||
    (DE_RS2_USED && (DE_RS2_ADDR == EX_RD_ADDR));

  assign w_load_use = r_v_de && r_v_ex && EX_MEMREAD &&
                      (EX_RD_ADDR != 5'd0) && w_lu_hit;

  // One-hot control modes; priority is folded into the terms
  assign w_idle    = !RESET && (r_state == S_IDLE);
  assign w_m_redir = w_idle && w_redir;
  assign w_m_entry = w_idle && !w_redir && w_int_req;
  assign w_m_stall = w_idle && !w_redir && !w_int_req && w_load_use;
  assign w_m_drain = !RESET && (r_state == S_DRAIN);
  assign w_m_take  = !RESET && (r_state == S_TAKE);

  always_comb begin
    PC_WRITE    = 1'b1;
    IF_DE_WRITE = 1'b1;
    IF_DE_FLUSH = 1'b0;
    DE_BUBBLE   = 1'b0;
    unique case (1'b1)
      RESET: begin
        PC_WRITE    = 1'b0;
        IF_DE_WRITE = 1'b0;
        DE_BUBBLE   = 1'b1;
      end
      w_m_redir, w_m_take: begin
        IF_DE_FLUSH = 1'b1;
        DE_BUBBLE   = 1'b1;
      end
      w_m_entry, w_m_stall, w_m_drain: begin
        PC_WRITE    = 1'b0;
        IF_DE_WRITE = 1'b0;
        DE_BUBBLE   = 1'b1;
      end
      default: begin
        PC_WRITE    = 1'b1;
        IF_DE_WRITE = 1'b1;
      end
    endcase
  end

  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic       mv,
    input logic       mrw,
    input logic [4:0] mrd,
    input logic       wv,
    input logic       wrw,
    input logic [4:0] wrd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (rs != 5'd0) && mv && mrw && (mrd == rs))
      sel = 2'b01;
    else if (used && (rs != 5'd0) && wv && wrw && (wrd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  assign FWD_A_SEL = fwd_sel(EX_RS1_USED, EX_RS1_ADDR,
                             r_v_mem, MEM_REGWRITE, MEM_RD_ADDR,
                             r_v_wb, WB_REGWRITE, WB_RD_ADDR);
  assign FWD_B_SEL = fwd_sel(EX_RS2_USED, EX_RS2_ADDR,
                             r_v_mem, MEM_REGWRITE, MEM_RD_ADDR,
                             r_v_wb, WB_REGWRITE, WB_RD_ADDR);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_v_de  <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_mem <= 1'b0;
      r_v_wb  <= 1'b0;
    end else begin
      if (IF_DE_FLUSH)
        r_v_de <= 1'b0;
      else if (IF_DE_WRITE)
        r_v_de <= 1'b1;
      r_v_ex  <= DE_BUBBLE ? 1'b0 : r_v_de;
      r_v_mem <= r_v_ex;
      r_v_wb  <= r_v_mem;
    end
  end

  // Three DRAIN cycles empty EX/MEM/WB; IF/DE keeps the mepc PC
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_int_taken <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_int_taken <= 1'b0;
          r_cnt       <= 2'd0;
          if (w_int_req && !w_redir)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_cnt == 2'd2) begin
            r_state     <= S_TAKE;
            r_int_taken <= 1'b1;
            r_cnt       <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_TAKE: begin
          r_state     <= S_IDLE;
          r_int_taken <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_int_taken <= 1'b0;
          r_cnt       <= 2'd0;
        end
      endcase
    end
  end

  assign DE_VALID  = r_v_de;
  assign EX_VALID  = r_v_ex;
  assign MEM_VALID = r_v_mem;
  assign WB_VALID  = r_v_wb;
  assign INT_TAKEN = r_int_taken;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl: driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares.
module tb_otter_hazard_ctrl;

  logic       CLK;
  logic       RESET;
  logic [4:0] DE_RS1_ADDR, DE_RS2_ADDR;
  logic       DE_RS1_USED, DE_RS2_USED;
  logic [4:0] EX_RS1_ADDR, EX_RS2_ADDR;
  logic       EX_RS1_USED, EX_RS2_USED;
  logic [4:0] EX_RD_ADDR;
  logic       EX_MEMREAD;
  logic [4:0] MEM_RD_ADDR, WB_RD_ADDR;
  logic       MEM_REGWRITE, WB_REGWRITE;
  logic       EX_REDIRECT, INTR, MIE;
  logic       PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_BUBBLE;
  logic       DE_VALID, EX_VALID, MEM_VALID, WB_VALID;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;
  logic       INT_TAKEN;

  otter_hazard_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .DE_RS1_USED(DE_RS1_USED), .DE_RS2_USED(DE_RS2_USED),
    .EX_RS1_ADDR(EX_RS1_ADDR), .EX_RS2_ADDR(EX_RS2_ADDR),
    .EX_RS1_USED(EX_RS1_USED), .EX_RS2_USED(EX_RS2_USED),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_MEMREAD(EX_MEMREAD),
    .MEM_RD_ADDR(MEM_RD_ADDR), .WB_RD_ADDR(WB_RD_ADDR),
    .MEM_REGWRITE(MEM_REGWRITE), .WB_REGWRITE(WB_REGWRITE),
    .EX_REDIRECT(EX_REDIRECT), .INTR(INTR), .MIE(MIE),
    .PC_WRITE(PC_WRITE), .IF_DE_WRITE(IF_DE_WRITE),
    .IF_DE_FLUSH(IF_DE_FLUSH), .DE_BUBBLE(DE_BUBBLE),
    .DE_VALID(DE_VALID), .EX_VALID(EX_VALID),
    .MEM_VALID(MEM_VALID), .WB_VALID(WB_VALID),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .INT_TAKEN(INT_TAKEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  string       q_nm[$];
  logic [12:0] q_exp[$];
  int          checks = 0;
  int          errors = 0;

  string       m_nm;
  logic [12:0] m_exp;
  logic [12:0] m_act;

  // {pcw,ifw,flush,bubble} {de,ex,mem,wb} fwdA fwdB int_taken
  function automatic logic [12:0] e(input logic [3:0] c,
                                    input logic [3:0] v,
                                    input logic [1:0] fa,
                                    input logic [1:0] fb,
                                    input logic       it);
    return {c, v, fa, fb, it};
  endfunction

  always @(negedge CLK) begin
    if (q_exp.size() > 0) begin
      m_nm  = q_nm.pop_front();
      m_exp = q_exp.pop_front();
      m_act = {PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_BUBBLE,
               DE_VALID, EX_VALID, MEM_VALID, WB_VALID,
               FWD_A_SEL, FWD_B_SEL, INT_TAKEN};
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s got %b want %b", m_nm, m_act, m_exp);
      end
    end
  end

  task automatic cyc(input string nm, input logic [12:0] ex);
    q_nm.push_back(nm);
    q_exp.push_back(ex);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    DE_RS1_ADDR = 0; DE_RS2_ADDR = 0;
    DE_RS1_USED = 0; DE_RS2_USED = 0;
    EX_RS1_ADDR = 0; EX_RS2_ADDR = 0;
    EX_RS1_USED = 0; EX_RS2_USED = 0;
    EX_RD_ADDR = 0; EX_MEMREAD = 0;
    MEM_RD_ADDR = 0; WB_RD_ADDR = 0;
    MEM_REGWRITE = 0; WB_REGWRITE = 0;
    EX_REDIRECT = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; INTR = 1'b0; MIE = 1'b0;
    clr();
    @(posedge CLK);
    #1;
    cyc("reset_hold", e(4'b0001, 4'b0000, 2'b00, 2'b00, 1'b0));
    RESET = 1'b0;
    cyc("rel_c0", e(4'b1100, 4'b0000, 2'b00, 2'b00, 1'b0));
    cyc("rel_c1", e(4'b1100, 4'b1000, 2'b00, 2'b00, 1'b0));
    cyc("rel_c2", e(4'b1100, 4'b1100, 2'b00, 2'b00, 1'b0));
    cyc("rel_c3", e(4'b1100, 4'b1110, 2'b00, 2'b00, 1'b0));
    cyc("rel_c4", e(4'b1100, 4'b1111, 2'b00, 2'b00, 1'b0));

    // load to x0 never stalls
    EX_MEMREAD = 1; EX_RD_ADDR = 0; DE_RS1_USED = 1; DE_RS1_ADDR = 0;
    cyc("lu_x0", e(4'b1100, 4'b1111, 2'b00, 2'b00, 1'b0));
    // load rd=5, DE uses rs1=5
    EX_RD_ADDR = 5; DE_RS1_ADDR = 5;
    cyc("lu_stall", e(4'b0001, 4'b1111, 2'b00, 2'b00, 1'b0));
    clr();
    DE_RS1_USED = 1; DE_RS1_ADDR = 5;
    MEM_RD_ADDR = 5; MEM_REGWRITE = 1;
    cyc("lu_bubble", e(4'b1100, 4'b1011, 2'b00, 2'b00, 1'b0));
    clr();
    EX_RS1_USED = 1; EX_RS1_ADDR = 5;
    MEM_RD_ADDR = 5; MEM_REGWRITE = 1;
    WB_RD_ADDR = 5; WB_REGWRITE = 1;
    cyc("lu_fwd_wb", e(4'b1100, 4'b1101, 2'b10, 2'b00, 1'b0));
    clr();
    cyc("lu_refill", e(4'b1100, 4'b1110, 2'b00, 2'b00, 1'b0));

    EX_RS2_USED = 1; EX_RS2_ADDR = 7;
    MEM_RD_ADDR = 7; MEM_REGWRITE = 1;
    WB_RD_ADDR = 7; WB_REGWRITE = 1;
    cyc("fwd_mem_pri", e(4'b1100, 4'b1111, 2'b00, 2'b01, 1'b0));
    MEM_REGWRITE = 0;
    cyc("fwd_wb_only", e(4'b1100, 4'b1111, 2'b00, 2'b10, 1'b0));
    EX_RS2_ADDR = 0; MEM_RD_ADDR = 0; WB_RD_ADDR = 0;
    MEM_REGWRITE = 1;
    cyc("fwd_x0", e(4'b1100, 4'b1111, 2'b00, 2'b00, 1'b0));
    clr();
    EX_RS1_ADDR = 9; MEM_RD_ADDR = 9; MEM_REGWRITE = 1;
    EX_RS2_USED = 1; EX_RS2_ADDR = 9;
    cyc("fwd_unused", e(4'b1100, 4'b1111, 2'b00, 2'b01, 1'b0));
    clr();

    // redirect beats a simultaneous load-use
    EX_REDIRECT = 1;
    EX_MEMREAD = 1; EX_RD_ADDR = 5; DE_RS1_USED = 1; DE_RS1_ADDR = 5;
    cyc("redir", e(4'b1111, 4'b1111, 2'b00, 2'b00, 1'b0));
    clr();
    cyc("redir_p1", e(4'b1100, 4'b0011, 2'b00, 2'b00, 1'b0));
    cyc("redir_p2", e(4'b1100, 4'b1001, 2'b00, 2'b00, 1'b0));
    cyc("redir_p3", e(4'b1100, 4'b1100, 2'b00, 2'b00, 1'b0));
    cyc("redir_p4", e(4'b1100, 4'b1110, 2'b00, 2'b00, 1'b0));
    cyc("redir_p5", e(4'b1100, 4'b1111, 2'b00, 2'b00, 1'b0));

    INTR = 1; MIE = 1;
    cyc("int_entry", e(4'b0001, 4'b1111, 2'b00, 2'b00, 1'b0));
    cyc("int_drain1", e(4'b0001, 4'b1011, 2'b00, 2'b00, 1'b0));
    INTR = 0;
    cyc("int_drain2", e(4'b0001, 4'b1001, 2'b00, 2'b00, 1'b0));
    cyc("int_drain3", e(4'b0001, 4'b1000, 2'b00, 2'b00, 1'b0));
    cyc("int_take", e(4'b1111, 4'b1000, 2'b00, 2'b00, 1'b1));
    MIE = 0; INTR = 1;
    cyc("int_post1", e(4'b1100, 4'b0000, 2'b00, 2'b00, 1'b0));
    cyc("int_post2", e(4'b1100, 4'b1000, 2'b00, 2'b00, 1'b0));
    INTR = 0;
    cyc("int_post3", e(4'b1100, 4'b1100, 2'b00, 2'b00, 1'b0));
    cyc("int_post4", e(4'b1100, 4'b1110, 2'b00, 2'b00, 1'b0));
    cyc("int_post5", e(4'b1100, 4'b1111, 2'b00, 2'b00, 1'b0));

    INTR = 1; MIE = 1; EX_REDIRECT = 1;
    cyc("coll_redir", e(4'b1111, 4'b1111, 2'b00, 2'b00, 1'b0));
    EX_REDIRECT = 0;
    cyc("coll_entry", e(4'b0001, 4'b0011, 2'b00, 2'b00, 1'b0));
    cyc("coll_drain", e(4'b0001, 4'b0001, 2'b00, 2'b00, 1'b0));
    RESET = 1;
    cyc("mid_rst", e(4'b0001, 4'b0000, 2'b00, 2'b00, 1'b0));
    RESET = 0; INTR = 0; MIE = 0;
    cyc("rst_idle0", e(4'b1100, 4'b0000, 2'b00, 2'b00, 1'b0));
    cyc("rst_idle1", e(4'b1100, 4'b1000, 2'b00, 2'b00, 1'b0));
    cyc("rst_idle2", e(4'b1100, 4'b1100, 2'b00, 2'b00, 1'b0));
    cyc("rst_idle3", e(4'b1100, 4'b1110, 2'b00, 2'b00, 1'b0));

    for (int i = 0; i < 4 && q_exp.size() > 0; i++)
      @(negedge CLK);
    #1;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
